musb_bus_demux_1_2: RTL and testbench
=====================================

// Module: musb_bus_demux_1_2
// PURPOSE
//  Routes one bus master (CPU data port) to one of two slaves: slave0 (memory), slave1 (I/O region).
//  Slave choice comes from an address decode. Request signals to the slave are registered.
//  Each transaction has a 3-state handshake FSM and an optional slave-timeout watchdog.
//  Sits between the core's data-memory port and the memory/peripheral buses.
// PARAMETERS
//  ADDR     32            address width
//  DATA     32            data width (multiple of 8)
//  S1_BASE  32'h1100_0000 slave1 base: (m_addr & S1_MASK) == S1_BASE selects slave1
//  S1_MASK  32'hFF00_0000 slave1 decode mask
//  TIMEOUT  255           cycles waited for sN_ready before abort; 0 = watchdog disabled
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  m_enable   in   1       master request; held with its payload until m_ready is seen
//  m_addr     in   ADDR    request address
//  m_wdata    in   DATA    write data
//  m_we       in   1       1 = write, 0 = read
//  m_be       in   DATA/8  byte enables
//  m_ready    out  1       1-cycle completion pulse
//  m_rdata    out  DATA    read data; valid only while m_ready = 1
//  m_error    out  1       1 together with m_ready when the transaction timed out
//  sN_enable  out  1       slave N request (N = 0, 1), registered
//  sN_addr    out  ADDR    registered copy of m_addr
//  sN_wdata   out  DATA    registered copy of m_wdata
//  sN_we      out  1       registered copy of m_we
//  sN_be      out  DATA/8  registered copy of m_be
//  sN_ready   in   1       slave N done; sampled only while the FSM is busy on slave N
//  sN_rdata   in   DATA    slave N read data; valid with sN_ready
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (sN_* and m_*); timeout counter 0. Applies immediately and asynchronously,
//   including mid-transaction. A transaction in flight is dropped; no m_ready is produced for it.
//  States and transitions:
//   IDLE -> BUSY0 / BUSY1 when m_enable = 1. Decode picks 0 or 1.
//   BUSYn -> RESP when sn_ready = 1, or when the counter reaches TIMEOUT - 1.
//   RESP -> IDLE unconditionally.
//  Accept edge (IDLE, m_enable = 1):
//   - latch addr/wdata/we/be into the shared sN_* payload registers (both slaves see the same payload);
//   - set only the selected sN_enable;
//   - clear the counter.
//  BUSYn:
//   - sn_enable stays 1; the other slave's enable stays 0;
//   - the counter increments each cycle (saturates; frozen when TIMEOUT = 0).
//  Completion edge (sn_ready = 1):
//   - sn_enable <= 0;
//   - m_rdata <= sn_rdata for reads, 0 for writes;
//   - m_error <= 0.
//  Timeout edge (counter = TIMEOUT - 1 and sn_ready = 0):
//   - sn_enable <= 0; m_rdata <= 0; m_error <= 1.
//   - If sn_ready and timeout fall in the same cycle, ready wins (m_error = 0).
//  RESP: m_ready = 1 for exactly one cycle. m_rdata and m_error are cleared on exit.
//  Latency:
//   - m_enable seen in cycle T gives sN_enable high in T+1.
//   - sN_ready seen in cycle R gives m_ready in R+1.
//   - Minimum round trip, slave ready in T+1: m_ready in T+2, next accept in T+3.
//  Master deasserts or changes m_enable after it sees m_ready. m_enable still 1 in the IDLE cycle after RESP
//   is a new request.
//  sN_ready outside BUSYn, or from the non-selected slave, is ignored.
//  Payload changes on m_* while busy are ignored: the payload is captured once at accept.
//  Decode is on m_addr at accept only. Address wrap has no special meaning.
// STRUCTURE
//  Shared defines include musb_bus_defines.vh:
//   - state encodings IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2, RESP = 2'd3;
//   - default S1_BASE/S1_MASK, shared with the address-map checker.
//  Counter width: $clog2(TIMEOUT+1), minimum 1.
//  Sub-module: musb_bus_watchdog (load/clear, enable, terminal-count flag); reused by later bus bridges.
//  Everything else stays inline: FSM, decode, payload and read-data registers.
// TESTING
//  1. Read to memory: m_addr = 0x0000_0040, s0 ready 3 cycles after s0_enable, s0_rdata = 0xDEAD_BEEF
//     -> m_ready one cycle later, m_rdata = 0xDEAD_BEEF, m_error = 0, s1_enable never 1.
//  2. Write to I/O: m_addr = 0x1100_0004, m_we = 1, m_be = 4'b0011, m_wdata = 0x1234_5678
//     -> s1_enable = 1 with that exact payload; after s1_ready, m_ready = 1 and m_rdata = 0.
//  3. Timeout with TIMEOUT = 8 and s0_ready held at 0
//     -> s0_enable high exactly 8 cycles, then m_ready = 1, m_error = 1, m_rdata = 0; FSM back in IDLE.
//  4. Back-to-back: m_enable kept 1 with a new addr 0x1100_0008 in the cycle after m_ready
//     -> accepted that cycle, s1_enable the next cycle; the previous transaction's data is not reused.
//  5. Reset mid-BUSY1: rst_n low for 1 cycle while s1_enable = 1
//     -> s1_enable and all outputs 0 immediately; no m_ready; a later s1_ready pulse is ignored.
//  6. Races: s0_ready in the timeout cycle -> m_error = 0. s1_ready pulsed during BUSY0 -> no effect.

Source files
------------

// File: rtl/musb_bus_demux_1_2_pkg.sv
// -----------------------------------------------------------------------------
// musb_bus_demux_1_2_pkg
//   Shared constants for the CPU data-port demultiplexer and the bus bridges
//   that reuse its watchdog.
//   - FSM state encodings (IDLE/BUSY0/BUSY1/RESP).
//   - Default slave1 decode window, also consumed by the address-map checker.
//   - Watchdog counter width helper.
// -----------------------------------------------------------------------------
package musb_bus_demux_1_2_pkg;

    // Handshake FSM encodings. Kept as plain 2-bit constants so that
    // older bridges comparing raw state values keep working.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BUSY0 = 2'd1;
    localparam logic [1:0] ST_BUSY1 = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Default I/O window: anything in 0x11xx_xxxx goes to slave1.
    localparam logic [31:0] DEF_S1_BASE = 32'h1100_0000;
    localparam logic [31:0] DEF_S1_MASK = 32'hFF00_0000;
    localparam int unsigned DEF_TIMEOUT = 255;

    // Which downstream slave a request targets.
    typedef enum logic {
        TGT_MEM = 1'b0,
        TGT_IO  = 1'b1
    } target_e;

    // Counter width able to hold TIMEOUT; a disabled watchdog (0) still
    // gets a 1-bit counter so the port list never collapses to zero width.
    function automatic int unsigned wd_width(input int unsigned timeout);
        if (timeout == 0) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/musb_bus_demux_1_2_if.sv
// -----------------------------------------------------------------------------
// musb_bus_demux_1_2_if
//   Simple request/ready memory bus used on both sides of the demux.
//   Request : enable, addr, wdata, we, be  (initiator -> target)
//   Response: ready, rdata, error          (target -> initiator)
//   Modports:
//     master - initiator view (drives the request, observes ready/rdata).
//     slave  - target view (observes the request, drives the response,
//              including error for targets that can report one).
// -----------------------------------------------------------------------------
interface musb_bus_demux_1_2_if #(
    parameter int ADDR = 32,
    parameter int DATA = 32
);
    logic                enable;
    logic [ADDR-1:0]     addr;
    logic [DATA-1:0]     wdata;
    logic                we;
    logic [DATA/8-1:0]   be;
    logic                ready;
    logic [DATA-1:0]     rdata;
    logic                error;

    // Downstream memories/peripherals never report errors, so the
    // initiator view does not take one.
    modport master (
        output enable, addr, wdata, we, be,
        input  ready, rdata
    );

    modport slave (
        input  enable, addr, wdata, we, be,
        output ready, rdata, error
    );
endinterface

// File: rtl/musb_bus_demux_1_2_watchdog.sv
// -----------------------------------------------------------------------------
// musb_bus_watchdog
//   Saturating cycle counter with a terminal-count flag, used to abort
//   transactions whose target never answers.
//   Ports:
//     clk    in  clock, rising edge
//     rst_n  in  asynchronous active-low reset (counter -> 0)
//     clr_i  in  clear the counter (takes priority over en_i)
//     en_i   in  count this cycle
//     tc_o   out high while counting and the count equals TIMEOUT-1
//   TIMEOUT = 0 disables the watchdog: the counter stays frozen at 0 and
//   tc_o never asserts.
// -----------------------------------------------------------------------------
module musb_bus_watchdog
    import musb_bus_demux_1_2_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW     = wd_width(TIMEOUT);
    localparam bit          WD_ON  = (TIMEOUT != 0);
    localparam int unsigned TC_INT = WD_ON ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TC_VAL = CW'(TC_INT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (WD_ON && en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = WD_ON && en_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/musb_bus_demux_1_2.sv
// -----------------------------------------------------------------------------
// musb_bus_demux_1_2
//   Routes the CPU data port to either memory (slave0) or the I/O region
//   (slave1). The slave is chosen by address decode when the request is
//   accepted; the request payload is registered once and presented to both
//   slaves, only the selected slave sees its enable.
//   Every transaction walks IDLE -> BUSYn -> RESP -> IDLE; RESP produces a
//   one-cycle m_ready with the captured read data, or with error set when
//   the watchdog expired first.
//   Ports:
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset; drops any transaction
//     m_if   slave modport  - CPU side (enable/addr/wdata/we/be in,
//                             ready/rdata/error out)
//     s0_if  master modport - memory side (registered request out,
//                             ready/rdata in)
//     s1_if  master modport - I/O side, same as s0_if
// -----------------------------------------------------------------------------
module musb_bus_demux_1_2
    import musb_bus_demux_1_2_pkg::*;
#(
    parameter int unsigned      ADDR    = 32,
    parameter int unsigned      DATA    = 32,
    parameter logic [ADDR-1:0]  S1_BASE = ADDR'(DEF_S1_BASE),
    parameter logic [ADDR-1:0]  S1_MASK = ADDR'(DEF_S1_MASK),
    parameter int unsigned      TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    musb_bus_demux_1_2_if.slave    m_if,
    musb_bus_demux_1_2_if.master   s0_if,
    musb_bus_demux_1_2_if.master   s1_if
);

    localparam int unsigned BE_W = DATA / 8;

    // ---------------------------------------------------------------- state
    logic [1:0]        state_q,  state_d;
    logic [1:0]        s_en_q,   s_en_d;     // bit n = slave n enable
    logic [ADDR-1:0]   addr_q,   addr_d;
    logic [DATA-1:0]   wdata_q,  wdata_d;
    logic              we_q,     we_d;
    logic [BE_W-1:0]   be_q,     be_d;
    logic [DATA-1:0]   rdata_q,  rdata_d;
    logic              err_q,    err_d;

    // ------------------------------------------------- slave response view
    logic [1:0]        s_ready;
    logic [DATA-1:0]   s_rdata [2];

    assign s_ready[0] = s0_if.ready;
    assign s_ready[1] = s1_if.ready;
    assign s_rdata[0] = s0_if.rdata;
    assign s_rdata[1] = s1_if.rdata;

    // ---------------------------------------------------------- decode etc.
    target_e tgt;
    logic    accept;
    logic    busy;
    logic    cur;          // slave currently being served while busy
    logic    hit_ready;    // selected slave answered this cycle
    logic    wd_tc;

    assign tgt       = ((m_if.addr & S1_MASK) == S1_BASE) ? TGT_IO : TGT_MEM;
    assign accept    = (state_q == ST_IDLE) && m_if.enable;
    assign busy      = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
    assign cur       = (state_q == ST_BUSY1);
    // Only the slave being served is looked at; the other one's ready
    // (and any ready outside BUSYn) is ignored.
    assign hit_ready = busy && s_ready[cur];

    musb_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (accept),
        .en_i  (busy),
        .tc_o  (wd_tc)
    );

    // ------------------------------------------------------ next-state logic
    always_comb begin
        state_d = state_q;
        s_en_d  = s_en_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (m_if.enable) begin
                    addr_d  = m_if.addr;
                    wdata_d = m_if.wdata;
                    we_d    = m_if.we;
                    be_d    = m_if.be;
                    if (tgt == TGT_IO) begin
                        state_d = ST_BUSY1;
                        s_en_d  = 2'b10;
                    end else begin
                        state_d = ST_BUSY0;
                        s_en_d  = 2'b01;
                    end
                end
            end

            ST_BUSY0, ST_BUSY1: begin
                // Ready is checked first so a response landing in the
                // terminal-count cycle still completes without error.
                if (hit_ready) begin
                    state_d = ST_RESP;
                    s_en_d  = 2'b00;
                    rdata_d = we_q ? '0 : s_rdata[cur];
                    err_d   = 1'b0;
                end else if (wd_tc) begin
                    state_d = ST_RESP;
                    s_en_d  = 2'b00;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                s_en_d  = 2'b00;
            end
        endcase
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_en_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_en_q  <= s_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // ----------------------------------------------------------------- outputs
    assign m_if.ready = (state_q == ST_RESP);
    assign m_if.rdata = rdata_q;
    assign m_if.error = err_q;

    // Both slaves share one payload register set.
    assign s0_if.enable = s_en_q[0];
    assign s0_if.addr   = addr_q;
    assign s0_if.wdata  = wdata_q;
    assign s0_if.we     = we_q;
    assign s0_if.be     = be_q;

    assign s1_if.enable = s_en_q[1];
    assign s1_if.addr   = addr_q;
    assign s1_if.wdata  = wdata_q;
    assign s1_if.we     = we_q;
    assign s1_if.be     = be_q;

endmodule

// File: tb/tb_musb_bus_demux_1_2.sv
// -----------------------------------------------------------------------------
// tb_musb_bus_demux_1_2
//   Directed table of transactions, a reset-in-flight sequence and a batch
//   of random transactions checked against a transaction-level model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_musb_bus_demux_1_2;

    localparam int          TO      = 8;
    localparam logic [31:0] S1_BASE = 32'h1100_0000;
    localparam logic [31:0] S1_MASK = 32'hFF00_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    musb_bus_demux_1_2_if #(.ADDR(32), .DATA(32)) m_bus ();
    musb_bus_demux_1_2_if #(.ADDR(32), .DATA(32)) s0_bus ();
    musb_bus_demux_1_2_if #(.ADDR(32), .DATA(32)) s1_bus ();

    musb_bus_demux_1_2 #(
        .ADDR    (32),
        .DATA    (32),
        .S1_BASE (S1_BASE),
        .S1_MASK (S1_MASK),
        .TIMEOUT (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m_if  (m_bus),
        .s0_if (s0_bus),
        .s1_if (s1_bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Expected outcome of one transaction.
    typedef struct {
        bit          sel;        // 1 = slave1
        int          en_cycles;  // cycles the selected enable is high
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    // Transaction-level model: the slave answers d cycles after its enable
    // rises; the answer only counts if it lands inside the TO-cycle window.
    function automatic exp_t model(input logic [31:0] addr, input bit we,
                                   input int d, input logic [31:0] srd);
        exp_t e;
        e.sel       = ((addr & S1_MASK) == S1_BASE);
        e.err       = (d >= TO);
        e.en_cycles = e.err ? TO : d + 1;
        e.rdata     = (e.err || we) ? 32'h0 : srd;
        return e;
    endfunction

    // Runs one transaction. Entry and exit: at a falling edge in an IDLE cycle.
    // b2b keeps m_enable high through RESP/IDLE so the next call's payload is
    // accepted at the end of that IDLE cycle.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input bit we, input logic [3:0] be, input int d,
                           input logic [31:0] srd, input bit b2b, input bit scramble,
                           input exp_t e);
        int          first_en = -1;
        int          en_cnt   = 0;
        int          ready_c  = -1;
        int          busy_idx = 0;
        int          pay_bad  = 0;
        bit          other    = 1'b0;
        logic        sel_en, oth_en;
        logic [31:0] got_rd   = 32'h0;
        logic        got_err  = 1'b0;

        m_bus.enable = 1'b1;
        m_bus.addr   = addr;
        m_bus.wdata  = wdata;
        m_bus.we     = we;
        m_bus.be     = be;

        for (int c = 1; c <= 40 && ready_c < 0; c++) begin
            @(negedge clk);
            s0_bus.ready = 1'b0;
            s1_bus.ready = 1'b0;
            sel_en = e.sel ? s1_bus.enable : s0_bus.enable;
            oth_en = e.sel ? s0_bus.enable : s1_bus.enable;
            if (oth_en) other = 1'b1;
            if (m_bus.ready) begin
                ready_c = c;
                got_rd  = m_bus.rdata;
                got_err = m_bus.error;
            end else begin
                if (sel_en) begin
                    if (first_en < 0) first_en = c;
                    en_cnt++;
                    if ({s0_bus.addr, s0_bus.wdata, s0_bus.we, s0_bus.be} !== {addr, wdata, we, be} ||
                        {s1_bus.addr, s1_bus.wdata, s1_bus.we, s1_bus.be} !== {addr, wdata, we, be})
                        pay_bad++;
                    if (busy_idx == d) begin
                        if (e.sel) begin s1_bus.ready = 1'b1; s1_bus.rdata = srd; end
                        else       begin s0_bus.ready = 1'b1; s0_bus.rdata = srd; end
                    end
                    busy_idx++;
                end
                // Noise from the slave that is not being served.
                if (e.sel) begin s0_bus.ready = 1'($urandom_range(0, 1)); s0_bus.rdata = $urandom; end
                else       begin s1_bus.ready = 1'($urandom_range(0, 1)); s1_bus.rdata = $urandom; end
                if (scramble) begin
                    m_bus.addr  = $urandom;
                    m_bus.wdata = $urandom;
                    m_bus.we    = 1'($urandom_range(0, 1));
                    m_bus.be    = 4'($urandom_range(0, 15));
                end
            end
        end

        if (ready_c < 0) check({tag, " m_ready within bound"}, 0, 1);
        check({tag, " first enable cycle"}, 64'(first_en), 1);
        check({tag, " enable cycles"}, 64'(en_cnt), 64'(e.en_cycles));
        check({tag, " other slave enabled"}, 64'(other), 0);
        check({tag, " payload mismatches"}, 64'(pay_bad), 0);
        check({tag, " m_ready cycle"}, 64'(ready_c), 64'(e.en_cycles + 1));
        check({tag, " m_rdata"}, 64'(got_rd), 64'(e.rdata));
        check({tag, " m_error"}, 64'(got_err), 64'(e.err));

        // RESP cycle: stray readies on both slaves must be ignored.
        m_bus.enable = b2b;
        s0_bus.ready = 1'b1; s0_bus.rdata = 32'hBAD0_0000;
        s1_bus.ready = 1'b1; s1_bus.rdata = 32'hBAD1_1111;
        @(negedge clk);
        check({tag, " idle after resp {ready,err,rdata,en1,en0}"},
              64'({m_bus.ready, m_bus.error, m_bus.rdata, s1_bus.enable, s0_bus.enable}), 0);
        $display("txn %s addr=%h we=%0d d=%0d -> en=%0d ready@%0d rdata=%h err=%0d",
                 tag, addr, we, d, en_cnt, ready_c, got_rd, got_err);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          we;
        logic [3:0]  be;
        int          d;
        logic [31:0] srd;
        bit          b2b;
        bit          sel;
        int          en;
        bit          err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        exp_t        e;
        logic [31:0] a, wd, sr, r;
        logic [3:0]  bev;
        bit          wev, bb;
        int          dv, pick, seen;

        //          addr          wdata         we be     d   srd           b2b sel en err rdata
        vecs[0] = '{32'h0000_0040, 32'h0,        0, 4'hF, 3,  32'hDEAD_BEEF, 0, 0, 4, 0, 32'hDEAD_BEEF};
        vecs[1] = '{32'h1100_0004, 32'h1234_5678,1, 4'h3, 1,  32'hA5A5_A5A5, 1, 1, 2, 0, 32'h0};
        vecs[2] = '{32'h1100_0008, 32'h0,        0, 4'hF, 0,  32'hCAFE_F00D, 0, 1, 1, 0, 32'hCAFE_F00D};
        vecs[3] = '{32'h0000_0100, 32'h0,        0, 4'hF, 99, 32'h1111_2222, 0, 0, 8, 1, 32'h0};
        vecs[4] = '{32'h0000_0200, 32'h0,        0, 4'hF, 7,  32'h0BAD_F00D, 0, 0, 8, 0, 32'h0BAD_F00D};
        vecs[5] = '{32'h11FF_FFFC, 32'h0,        0, 4'hF, 8,  32'h3333_4444, 0, 1, 8, 1, 32'h0};
        vecs[6] = '{32'h1200_0000, 32'hFFFF_0000,1, 4'hC, 2,  32'h5555_6666, 0, 0, 3, 0, 32'h0};
        vecs[7] = '{32'h10FF_FFFF, 32'h0,        0, 4'h1, 5,  32'h7777_8888, 0, 0, 6, 0, 32'h7777_8888};

        m_bus.enable = 1'b0; m_bus.addr = '0; m_bus.wdata = '0; m_bus.we = 1'b0; m_bus.be = '0;
        s0_bus.ready = 1'b0; s0_bus.rdata = '0; s0_bus.error = 1'b0;
        s1_bus.ready = 1'b0; s1_bus.rdata = '0; s1_bus.error = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        check("reset outputs zero",
              64'(|{m_bus.ready, m_bus.error, m_bus.rdata,
                    s0_bus.enable, s0_bus.addr, s0_bus.wdata, s0_bus.we, s0_bus.be,
                    s1_bus.enable, s1_bus.addr, s1_bus.wdata, s1_bus.we, s1_bus.be}), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            e.sel = vecs[i].sel; e.en_cycles = vecs[i].en;
            e.err = vecs[i].err; e.rdata = vecs[i].rdata;
            run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].be,
                    vecs[i].d, vecs[i].srd, vecs[i].b2b, 1'b0, e);
        end

        // Reset while slave1 is being served.
        s0_bus.ready = 1'b0; s1_bus.ready = 1'b0;
        m_bus.enable = 1'b1; m_bus.addr = 32'h1100_0010; m_bus.we = 1'b0; m_bus.be = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid s1_enable before reset", 64'(s1_bus.enable), 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid outputs cleared at once",
              64'(|{m_bus.ready, m_bus.error, m_bus.rdata, s0_bus.enable, s1_bus.enable,
                    s1_bus.addr, s1_bus.be}), 0);
        m_bus.enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s1_bus.ready = 1'b1; s1_bus.rdata = 32'hFEED_FACE;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s1_bus.ready = 1'b0;
            if (m_bus.ready || s0_bus.enable || s1_bus.enable) seen++;
        end
        check("rst_mid no response afterwards", 64'(seen), 0);
        $display("txn rst_mid: reset during BUSY1, activity after release=%0d", seen);

        // Random transactions against the model.
        for (int k = 0; k < 40; k++) begin
            r    = $urandom;
            pick = $urandom_range(0, 2);
            if (pick == 0)      a = {8'h11, r[23:0]};
            else if (pick == 1) a = $urandom;
            else                a = {8'h00, r[23:0]};
            wd  = $urandom;
            sr  = $urandom;
            wev = 1'($urandom_range(0, 1));
            bev = 4'($urandom_range(0, 15));
            dv  = $urandom_range(0, 11);
            bb  = 1'($urandom_range(0, 1));
            e   = model(a, wev, dv, sr);
            run_txn($sformatf("rnd%0d", k), a, wd, wev, bev, dv, sr, bb, 1'b1, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
